// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: multi-cycle stage sequencer for the core.
// It issues one-cycle stage enables (IF, ID, EX, MEM, WB) on the single core
// clock. It waits on the instruction and data memory ready handshakes, supports
// run, halt and single-step control, and counts retired instructions. A fetch
// or data request that waits too long parks the block in ERR until reset.
module core_seq_ctrl #(
  parameter int WAIT_MAX = 8,   // request cycles allowed with ready low (>= 1)
  parameter int CNT_W    = 32   // retired-instruction counter width
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_run,
  input  logic             i_step,
  input  logic             i_imemRdy,
  input  logic             i_dmemRdy,
  input  logic             i_needMem,
  output logic             o_imemReq,
  output logic             o_dmemReq,
  output logic             o_enIF,
  output logic             o_enID,
  output logic             o_enEX,
  output logic             o_enMEM,
  output logic             o_enWB,
  output logic [2:0]       o_state,
  output logic             o_halted,
  output logic             o_timeout,
  output logic [CNT_W-1:0] o_retired
);

  localparam int WCNT_W = $clog2(WAIT_MAX) + 1;

  // On the last allowed wait cycle, a missing ready sends the block to ERR.
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_MAX - 1);

  // The encoding is visible on o_state, so the values are fixed.
  typedef enum logic [2:0] {
    S_HALT = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5,
    S_ERR  = 3'd7
  } state_t;

  state_t            state;
  logic              mem_flag;   // decoded instruction uses MEM
  logic              step_flag;  // current instruction was started by i_step
  logic [WCNT_W-1:0] wait_cnt;   // ready-low cycles in the current IF/MEM

  // Sequencer state, wait counter, step/mem flags and retired counter.
  // NOTE: every register here uses non-blocking assignment. All of them then
  // update together at the edge, and the order of statements does not matter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= S_HALT;
      mem_flag  <= 1'b0;
      step_flag <= 1'b0;
      wait_cnt  <= '0;
      o_retired <= '0;
    end else begin
      case (state)
        S_HALT: begin
          // Run wins when run and step are seen together; the step is dropped.
          if (i_run) begin
            state     <= S_IF;
            step_flag <= 1'b0;
            wait_cnt  <= '0;
          end else if (i_step) begin
            state     <= S_IF;
            step_flag <= 1'b1;
            wait_cnt  <= '0;
          end
        end

        S_IF: begin
          if (i_imemRdy) begin
            state <= S_ID;
          end else if (wait_cnt == WAIT_LAST) begin
            state <= S_ERR;
          end else begin
            wait_cnt <= wait_cnt + WCNT_W'(1);
          end
        end

        S_ID: begin
          mem_flag <= i_needMem;
          state    <= S_EX;
        end

        S_EX: begin
          if (mem_flag) begin
            state    <= S_MEM;
            wait_cnt <= '0;
          end else begin
            state <= S_WB;
          end
        end

        S_MEM: begin
          if (i_dmemRdy) begin
            state <= S_WB;
          end else if (wait_cnt == WAIT_LAST) begin
            state <= S_ERR;
          end else begin
            wait_cnt <= wait_cnt + WCNT_W'(1);
          end
        end

        S_WB: begin
          o_retired <= o_retired + CNT_W'(1);
          // A stepped instruction always returns to HALT, even if run went high.
          if (i_run && !step_flag) begin
            state    <= S_IF;
            wait_cnt <= '0;
          end else begin
            state     <= S_HALT;
            step_flag <= 1'b0;
          end
        end

        // ERR is left only through i_reset; run and step are ignored.
        S_ERR:   state <= S_ERR;

        // The unused encoding is treated as a fault.
        default: state <= S_ERR;
      endcase
    end
  end

  // Stage enables and requests come from the state register.
  // IF and MEM are also gated by the live ready input.
  // NOTE: each output gets a default before the case. Without it, a path that
  // skips an assignment would infer a latch.
  always_comb begin
    o_imemReq = 1'b0;
    o_dmemReq = 1'b0;
    o_enIF    = 1'b0;
    o_enID    = 1'b0;
    o_enEX    = 1'b0;
    o_enMEM   = 1'b0;
    o_enWB    = 1'b0;
    case (state)
      S_IF: begin
        o_imemReq = 1'b1;
        o_enIF    = i_imemRdy;
      end
      S_ID:  o_enID = 1'b1;
      S_EX:  o_enEX = 1'b1;
      S_MEM: begin
        o_dmemReq = 1'b1;
        o_enMEM   = i_dmemRdy;
      end
      S_WB:  o_enWB = 1'b1;
      default: ;
    endcase
  end

  assign o_state   = state;
  assign o_halted  = (state == S_HALT);
  assign o_timeout = (state == S_ERR);

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Testbench for core_seq_ctrl.
// Directed scenarios come first. A randomized run then checks the DUT against
// an instruction-level model, which keeps a queue of the stages still due for
// the current instruction.
module tb_core_seq_ctrl;

  localparam int WM = 4;   // WAIT_MAX used for the DUT
  localparam int CW = 8;   // small counter so wrap-around is cheap to reach

  logic          i_clk, i_reset, i_run, i_step, i_imemRdy, i_dmemRdy, i_needMem;
  logic          o_imemReq, o_dmemReq;
  logic          o_enIF, o_enID, o_enEX, o_enMEM, o_enWB;
  logic [2:0]    o_state;
  logic          o_halted, o_timeout;
  logic [CW-1:0] o_retired;
  logic [4:0]    en;

  int total = 0;
  int bad   = 0;

  assign en = {o_enIF, o_enID, o_enEX, o_enMEM, o_enWB};

  core_seq_ctrl #(.WAIT_MAX(WM), .CNT_W(CW)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_run(i_run), .i_step(i_step),
    .i_imemRdy(i_imemRdy), .i_dmemRdy(i_dmemRdy), .i_needMem(i_needMem),
    .o_imemReq(o_imemReq), .o_dmemReq(o_dmemReq),
    .o_enIF(o_enIF), .o_enID(o_enID), .o_enEX(o_enEX), .o_enMEM(o_enMEM),
    .o_enWB(o_enWB), .o_state(o_state), .o_halted(o_halted),
    .o_timeout(o_timeout), .o_retired(o_retired)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Advance one clock; outputs are then read 1 time unit after the edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic apply_reset();
    i_reset = 1'b1; i_run = 1'b0; i_step = 1'b0;
    i_imemRdy = 1'b1; i_dmemRdy = 1'b1; i_needMem = 1'b0;
    tick();
    i_reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    tick();
    total++;
    if (o_state !== 3'd0 || o_halted !== 1'b1 || o_timeout !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: state=%0d halted=%b timeout=%b want 0/1/0",
               o_state, o_halted, o_timeout);
    end
    total++;
    if (en !== 5'b0 || o_imemReq !== 1'b0 || o_dmemReq !== 1'b0 || o_retired !== 8'd0) begin
      bad++;
      $display("FAIL reset_outputs: en=%b ireq=%b dreq=%b ret=%0d want all zero",
               en, o_imemReq, o_dmemReq, o_retired);
    end
  endtask

  task automatic test_basic_run();
    logic [4:0] pat [4];
    pat = '{5'b10000, 5'b01000, 5'b00100, 5'b00001};
    apply_reset();
    i_run = 1'b1;
    tick();
    for (int c = 0; c < 12; c++) begin
      total++;
      if (en !== pat[c % 4] || o_dmemReq !== 1'b0) begin
        bad++;
        $display("FAIL basic_run_en c=%0d: en=%b dreq=%b want en=%b dreq=0",
                 c, en, o_dmemReq, pat[c % 4]);
      end
      tick();
    end
    total++;
    if (o_retired !== 8'd3 || o_state !== 3'd1) begin
      bad++;
      $display("FAIL basic_run_retired: ret=%0d state=%0d want 3/1", o_retired, o_state);
    end
    i_run = 1'b0;
    repeat (4) tick();
    total++;
    if (o_halted !== 1'b1 || o_retired !== 8'd4) begin
      bad++;
      $display("FAIL basic_run_halt: halted=%b ret=%0d want 1/4", o_halted, o_retired);
    end
  endtask

  task automatic test_mem_path();
    logic [4:0] pat [5];
    pat = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001};
    apply_reset();
    i_run = 1'b1; i_needMem = 1'b1;
    tick();
    for (int c = 0; c < 10; c++) begin
      total++;
      if (en !== pat[c % 5] || o_dmemReq !== ((c % 5) == 3)) begin
        bad++;
        $display("FAIL mem_path_en c=%0d: en=%b dreq=%b want en=%b dreq=%b",
                 c, en, o_dmemReq, pat[c % 5], (c % 5) == 3);
      end
      tick();
    end
    total++;
    if (o_retired !== 8'd2) begin
      bad++;
      $display("FAIL mem_path_retired: ret=%0d want 2", o_retired);
    end
    i_run = 1'b0;
    repeat (5) tick();
  endtask

  // Ready arrives on the WAIT_MAX-th request cycle and must be accepted.
  task automatic test_fetch_wait();
    apply_reset();
    i_imemRdy = 1'b0; i_run = 1'b1;
    tick();
    for (int c = 0; c < WM - 1; c++) begin
      total++;
      if (o_state !== 3'd1 || o_imemReq !== 1'b1 || o_enIF !== 1'b0) begin
        bad++;
        $display("FAIL fetch_wait c=%0d: state=%0d ireq=%b enIF=%b want 1/1/0",
                 c, o_state, o_imemReq, o_enIF);
      end
      tick();
    end
    i_imemRdy = 1'b1;
    #1;
    total++;
    if (o_imemReq !== 1'b1 || o_enIF !== 1'b1) begin
      bad++;
      $display("FAIL fetch_accept: ireq=%b enIF=%b want 1/1", o_imemReq, o_enIF);
    end
    tick();
    total++;
    if (o_state !== 3'd2 || o_timeout !== 1'b0) begin
      bad++;
      $display("FAIL fetch_to_id: state=%0d timeout=%b want 2/0", o_state, o_timeout);
    end
    i_run = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_single_step();
    apply_reset();
    i_step = 1'b1;
    tick();                 // HALT -> IF
    i_step = 1'b0;
    tick();                 // IF -> ID
    i_step = 1'b1;          // this pulse arrives mid-instruction and is ignored
    tick();                 // ID -> EX
    i_step = 1'b0;
    tick();                 // EX -> WB
    tick();                 // WB -> HALT
    total++;
    if (o_halted !== 1'b1 || o_retired !== 8'd1) begin
      bad++;
      $display("FAIL step_one: halted=%b ret=%0d want 1/1", o_halted, o_retired);
    end
    repeat (3) tick();
    total++;
    if (o_halted !== 1'b1 || o_retired !== 8'd1) begin
      bad++;
      $display("FAIL step_no_queue: halted=%b ret=%0d want 1/1", o_halted, o_retired);
    end
    i_run = 1'b1; i_step = 1'b1;
    tick();
    i_step = 1'b0;
    repeat (8) tick();
    total++;
    if (o_state !== 3'd1 || o_retired !== 8'd3) begin
      bad++;
      $display("FAIL run_and_step: state=%0d ret=%0d want 1/3", o_state, o_retired);
    end
    i_run = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_timeout();
    apply_reset();
    i_run = 1'b1; i_dmemRdy = 1'b0;
    tick();
    repeat (4) tick();      // one no-MEM instruction retires
    i_needMem = 1'b1;
    repeat (3) tick();      // IF -> ID -> EX -> MEM
    for (int c = 0; c < WM; c++) begin
      total++;
      if (o_state !== 3'd4 || o_dmemReq !== 1'b1 || o_enMEM !== 1'b0) begin
        bad++;
        $display("FAIL timeout_wait c=%0d: state=%0d dreq=%b enMEM=%b want 4/1/0",
                 c, o_state, o_dmemReq, o_enMEM);
      end
      tick();
    end
    total++;
    if (o_state !== 3'd7 || o_timeout !== 1'b1 || en !== 5'b0 ||
        o_imemReq !== 1'b0 || o_dmemReq !== 1'b0) begin
      bad++;
      $display("FAIL timeout_err: state=%0d timeout=%b en=%b ireq=%b dreq=%b want 7/1/0/0/0",
               o_state, o_timeout, en, o_imemReq, o_dmemReq);
    end
    i_dmemRdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      i_run  = k[0];
      i_step = ~k[0];
      tick();
    end
    total++;
    if (o_state !== 3'd7 || o_retired !== 8'd1) begin
      bad++;
      $display("FAIL timeout_hold: state=%0d ret=%0d want 7/1", o_state, o_retired);
    end
    apply_reset();
    total++;
    if (o_state !== 3'd0 || o_timeout !== 1'b0 || o_retired !== 8'd0) begin
      bad++;
      $display("FAIL timeout_reset: state=%0d timeout=%b ret=%0d want 0/0/0",
               o_state, o_timeout, o_retired);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    i_run = 1'b1;
    tick();
    repeat (8) tick();      // two instructions retired, back in IF
    tick();                 // IF -> ID
    tick();                 // ID -> EX
    i_reset = 1'b1;
    #1;
    total++;
    if (o_state !== 3'd3 || o_retired !== 8'd2) begin
      bad++;
      $display("FAIL reset_mid_pre: state=%0d ret=%0d want 3/2", o_state, o_retired);
    end
    tick();
    total++;
    if (o_state !== 3'd0 || o_retired !== 8'd0 || o_enWB !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: state=%0d ret=%0d enWB=%b want 0/0/0",
               o_state, o_retired, o_enWB);
    end
    i_reset = 1'b0; i_run = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    apply_reset();
    i_run = 1'b1;
    tick();
    repeat (255 * 4) tick();
    total++;
    if (o_retired !== 8'd255) begin
      bad++;
      $display("FAIL wrap_pre: ret=%0d want 255", o_retired);
    end
    repeat (4) tick();
    total++;
    if (o_retired !== 8'd0 || o_state !== 3'd1) begin
      bad++;
      $display("FAIL wrap: ret=%0d state=%0d want 0/1", o_retired, o_state);
    end
    i_run = 1'b0;
    repeat (4) tick();
  endtask

  // Random inputs checked against an instruction-level model. The model keeps
  // the stages still due for the current instruction in a queue; when the
  // queue is empty the block is halted.
  task automatic test_random();
    int         plan[$];
    bit         m_err, m_step;
    int         m_waits, cur, es;
    logic [7:0] m_ret;
    logic [11:0] exp_v, got_v;
    apply_reset();
    plan = {}; m_err = 0; m_step = 0; m_waits = 0; m_ret = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      i_reset   = ($urandom_range(0, 299) == 0);
      i_run     = ($urandom_range(0, 9) < 7);
      i_step    = ($urandom_range(0, 3) == 0);
      i_imemRdy = ($urandom_range(0, 3) != 0);
      i_dmemRdy = ($urandom_range(0, 3) != 0);
      i_needMem = $urandom_range(0, 1);
      #1;
      cur = (plan.size() == 0) ? 0 : plan[0];
      es  = m_err ? 7 : cur;
      exp_v = {3'(es), es == 1, es == 4,
               es == 1 && i_imemRdy, es == 2, es == 3, es == 4 && i_dmemRdy, es == 5,
               es == 0, es == 7};
      got_v = {o_state, o_imemReq, o_dmemReq, en, o_halted, o_timeout};
      total++;
      if (got_v !== exp_v || o_retired !== m_ret) begin
        bad++;
        $display("FAIL random cyc=%0d: outs=%b ret=%0d want outs=%b ret=%0d",
                 cyc, got_v, o_retired, exp_v, m_ret);
      end
      total++;
      if ($countones(en) > 1) begin
        bad++;
        $display("FAIL one_enable cyc=%0d: en=%b want at most one bit", cyc, en);
      end
      @(posedge i_clk);
      if (i_reset) begin
        plan = {}; m_err = 0; m_step = 0; m_waits = 0; m_ret = 0;
      end else if (!m_err) begin
        if (plan.size() == 0) begin
          if (i_run || i_step) begin
            plan = {1, 2, 3, 5}; m_step = !i_run; m_waits = 0;
          end
        end else begin
          case (cur)
            1, 4: begin
              if ((cur == 1) ? i_imemRdy : i_dmemRdy) begin
                void'(plan.pop_front()); m_waits = 0;
              end else begin
                m_waits++;
                if (m_waits == WM) begin m_err = 1; plan = {}; end
              end
            end
            2: begin
              void'(plan.pop_front());
              if (i_needMem) plan.insert(1, 4);
            end
            3: void'(plan.pop_front());
            default: begin
              m_ret++;
              void'(plan.pop_front());
              if (i_run && !m_step) begin plan = {1, 2, 3, 5}; m_waits = 0; end
            end
          endcase
        end
      end
      #1;
    end
    i_reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_mem_path();
    test_fetch_wait();
    test_single_step();
    test_timeout();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
